// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking neuron core's synaptic datapath.
// FP32 field layout and a leading-zero helper live here so the adder stays readable.
package snn_pkg;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned NUM_SYN = 5;
  localparam int unsigned DATA_W  = 32;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP32_INF  = 32'h7F80_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  // Number of leading zeros in a 27-bit significand; 27 when the value is zero.
  function automatic logic [4:0] clz27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp32_adder.sv
// Combinational IEEE-754 binary32 adder: round-to-nearest-even, subnormals flushed to +0,
// every NaN result canonicalised to 0x7FC00000.
module fp32_adder
  import snn_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  fp32_t fa, fb, big, sml;
  logic  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic  a_is_big, eff_sub;

  logic [7:0]        exp_diff;
  logic [4:0]        shamt;
  logic [26:0]       big_ext, sml_ext, sml_shift, shift_mask;
  logic              sticky;
  logic [27:0]       raw_sum;
  logic [4:0]        lz;
  logic [26:0]       norm;
  logic signed [9:0] norm_exp, final_exp;
  logic              round_up;
  logic [24:0]       rounded;
  logic [22:0]       final_man;

  assign fa = fp32_t'(a);
  assign fb = fp32_t'(b);

  // Exponent 0 covers both zero and subnormal, which are treated alike.
  assign a_zero = (fa.exp == 8'd0);
  assign b_zero = (fb.exp == 8'd0);
  assign a_inf  = (fa.exp == 8'hFF) && (fa.man == 23'd0);
  assign b_inf  = (fb.exp == 8'hFF) && (fb.man == 23'd0);
  assign a_nan  = (fa.exp == 8'hFF) && (fa.man != 23'd0);
  assign b_nan  = (fb.exp == 8'hFF) && (fb.man != 23'd0);

  assign a_is_big = (a[30:0] >= b[30:0]);
  assign big      = a_is_big ? fa : fb;
  assign sml      = a_is_big ? fb : fa;
  assign eff_sub  = fa.sign ^ fb.sign;

  // Align, add/subtract, normalise, round. Three extra LSBs hold guard, round and sticky.
  always_comb begin
    exp_diff   = big.exp - sml.exp;
    shamt      = (exp_diff > 8'd26) ? 5'd27 : exp_diff[4:0];
    big_ext    = {1'b1, big.man, 3'b000};
    sml_ext    = {1'b1, sml.man, 3'b000};
    shift_mask = ~(27'h7FF_FFFF << shamt);
    sticky     = |(sml_ext & shift_mask);
    sml_shift  = sml_ext >> shamt;
    sml_shift[0] = sml_shift[0] | sticky;

    raw_sum = eff_sub ? ({1'b0, big_ext} - {1'b0, sml_shift})
                      : ({1'b0, big_ext} + {1'b0, sml_shift});
    lz = clz27(raw_sum[26:0]);

    if (raw_sum[27]) begin
      norm     = raw_sum[27:1];
      norm[0]  = raw_sum[1] | raw_sum[0];
      norm_exp = $signed({2'b00, big.exp}) + 10'sd1;
    end else begin
      norm     = raw_sum[26:0] << lz;
      norm_exp = $signed({2'b00, big.exp}) - $signed({5'b00000, lz});
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {1'b0, norm[26:3]} + {24'd0, round_up};
    if (rounded[24]) begin
      final_exp = norm_exp + 10'sd1;
      final_man = rounded[23:1];
    end else begin
      final_exp = norm_exp;
      final_man = rounded[22:0];
    end
  end

  always_comb begin
    sum = FP32_ZERO;
    if (a_nan || b_nan) begin
      sum = FP32_QNAN;
    end else if (a_inf && b_inf && eff_sub) begin
      sum = FP32_QNAN;
    end else if (a_inf) begin
      sum = {fa.sign, FP32_INF[30:0]};
    end else if (b_inf) begin
      sum = {fb.sign, FP32_INF[30:0]};
    end else if (a_zero && b_zero) begin
      sum = FP32_ZERO;
    end else if (a_zero) begin
      sum = b;
    end else if (b_zero) begin
      sum = a;
    end else if (raw_sum == 28'd0) begin
      sum = FP32_ZERO;
    end else if (final_exp >= 10'sd255) begin
      sum = {big.sign, FP32_INF[30:0]};
    end else if (final_exp <= 10'sd0) begin
      sum = FP32_ZERO;
    end else begin
      sum = {big.sign, final_exp[7:0], final_man};
    end
  end

endmodule

// File: rtl/snn_mac.sv
// Per-neuron synaptic accumulator: matches incoming spikes against a live fan-in table and
// accumulates the matching slot's FP32 weight, cleared at each timestep boundary.
module snn_mac #(
  parameter int unsigned NUM_SYN = snn_pkg::NUM_SYN,
  parameter int unsigned ADDR_W  = snn_pkg::ADDR_W
) (
  input  logic                                CLK,
  input  logic                                RESET_N,
  input  logic [ADDR_W-1:0]                   neuron_address,
  input  logic [ADDR_W-1:0]                   source_address,
  input  logic                                source_valid,
  input  logic [NUM_SYN*ADDR_W-1:0]           source_addresses_array,
  input  logic [NUM_SYN*snn_pkg::DATA_W-1:0]  weights_array,
  input  logic                                clear,
  output logic [snn_pkg::DATA_W-1:0]          mult_output
);
  import snn_pkg::*;

  logic              slot_hit, hit;
  logic [DATA_W-1:0] sel_w, add_sum;
  logic [DATA_W-1:0] acc_d, acc_q;

  // Slot 0 sits in the MSBs; scanning upward from it gives lowest-index priority.
  always_comb begin
    slot_hit = 1'b0;
    sel_w    = FP32_ZERO;
    for (int unsigned k = 0; k < NUM_SYN; k++) begin
      if (!slot_hit &&
          source_addresses_array[(NUM_SYN-1-k)*ADDR_W +: ADDR_W] == source_address) begin
        slot_hit = 1'b1;
        sel_w    = weights_array[(NUM_SYN-1-k)*DATA_W +: DATA_W];
      end
    end
  end

  assign hit = source_valid && (source_address != neuron_address) && slot_hit;

  fp32_adder u_fp32_adder (
    .a   (acc_q),
    .b   (sel_w),
    .sum (add_sum)
  );

  // A spike coinciding with clear opens the new timestep instead of being lost.
  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = hit ? sel_w : FP32_ZERO;
    end else if (hit) begin
      acc_d = add_sum;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      acc_q <= FP32_ZERO;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign mult_output = acc_q;

endmodule

// File: tb/tb_snn_mac.sv
// Scoreboard bench for snn_mac: stimulus queues hand-computed sums, a monitor compares them.
module tb_snn_mac;

  logic         CLK;
  logic         RESET_N;
  logic [11:0]  neuron_address;
  logic [11:0]  source_address;
  logic         source_valid;
  logic [59:0]  source_addresses_array;
  logic [159:0] weights_array;
  logic         clear;
  logic [31:0]  mult_output;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  snn_mac dut (
    .CLK                    (CLK),
    .RESET_N                (RESET_N),
    .neuron_address         (neuron_address),
    .source_address         (source_address),
    .source_valid           (source_valid),
    .source_addresses_array (source_addresses_array),
    .weights_array          (weights_array),
    .clear                  (clear),
    .mult_output            (mult_output)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: one registered result per issued cycle, read mid-cycle.
  always @(negedge CLK) begin : monitor
    logic [31:0] e;
    string       n;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check(n, mult_output, e);
    end
  end

  task automatic set_tab(input logic [11:0] nrn, input logic [59:0] addrs,
                         input logic [159:0] wts);
    neuron_address         = nrn;
    source_addresses_array = addrs;
    weights_array          = wts;
  endtask

  // One clock cycle of stimulus, with valid/clear pulsed for that cycle only.
  task automatic step(input logic [11:0] src, input logic vld, input logic clr,
                      input logic [31:0] expv, input string nm);
    @(negedge CLK);
    #1;
    source_address = src;
    source_valid   = vld;
    clear          = clr;
    @(posedge CLK);
    #1;
    source_valid = 1'b0;
    clear        = 1'b0;
    exp_q.push_back(expv);
    name_q.push_back(nm);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    RESET_N        = 1'b0;
    source_address = '0;
    source_valid   = 1'b0;
    clear          = 1'b0;
    set_tab(12'd0, '0, '0);
    #12;
    check("reset_value", mult_output, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Full fan-in sum, neuron 8
    set_tab(12'd8, {12'd3, 12'd4, 12'd5, 12'd6, 12'd7},
            {32'h4290B333, 32'h41975C29, 32'h42470A3D, 32'h0, 32'h42AE3852});
    step(12'd0, 1'b0, 1'b0, 32'h0,        "idle_after_reset");
    step(12'd3, 1'b1, 1'b0, 32'h4290B333, "full_spike3");
    step(12'd4, 1'b1, 1'b0, 32'h42B68A3D, "full_spike4");
    step(12'd5, 1'b1, 1'b0, 32'h430D07AE, "full_spike5");
    step(12'd7, 1'b1, 1'b0, 32'h436423D7, "full_spike7");
    step(12'd6, 1'b1, 1'b0, 32'h436423D7, "zero_weight_slot");
    step(12'd9, 1'b0, 1'b0, 32'h436423D7, "no_valid_hold");
    neuron_address = 12'd3;
    step(12'd3, 1'b1, 1'b0, 32'h436423D7, "self_spike_ignored");
    neuron_address = 12'd8;

    // Clear interplay
    step(12'd0, 1'b0, 1'b1, 32'h0,        "clear_alone");
    step(12'd3, 1'b1, 1'b1, 32'h4290B333, "clear_with_spike");
    step(12'd4, 1'b1, 1'b0, 32'h42B68A3D, "pre_reset_accum");

    // Asynchronous reset mid-accumulation
    @(negedge CLK);
    #3;
    RESET_N = 1'b0;
    #1;
    check("async_reset", mult_output, 32'h0);
    @(posedge CLK);
    #1;
    check("reset_held", mult_output, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    step(12'd0, 1'b0, 1'b0, 32'h0, "after_release_1");
    step(12'd0, 1'b0, 1'b0, 32'h0, "after_release_2");

    // Sparse table, neuron 4
    set_tab(12'd4, {12'd1, 12'd2, 12'd5, 12'd0, 12'd0},
            {32'h423F47AE, 32'h4109999A, 32'h0, 32'h0, 32'h0});
    step(12'd1, 1'b1, 1'b0, 32'h423F47AE, "sparse_spike1");
    step(12'd2, 1'b1, 1'b0, 32'h4261AE14, "sparse_spike2_tie");
    step(12'd9, 1'b1, 1'b0, 32'h4261AE14, "sparse_miss");
    step(12'd0, 1'b1, 1'b0, 32'h4261AE14, "padding_addr0");

    // Duplicate slots: slot 0 wins
    set_tab(12'd8, {12'd3, 12'd3, 12'd0, 12'd0, 12'd0},
            {32'h3F800000, 32'h40000000, 32'h0, 32'h0, 32'h0});
    step(12'd0, 1'b0, 1'b1, 32'h0,        "dup_clear");
    step(12'd3, 1'b1, 1'b0, 32'h3F800000, "dup_first");
    step(12'd3, 1'b1, 1'b0, 32'h40000000, "dup_second");

    // Specials
    set_tab(12'd8, {12'd3, 12'd0, 12'd0, 12'd0, 12'd0}, {32'h7F7FFFFF, 128'h0});
    step(12'd3, 1'b1, 1'b1, 32'h7F7FFFFF, "load_max");
    step(12'd3, 1'b1, 1'b0, 32'h7F800000, "overflow_inf");
    weights_array = {32'hFF800000, 128'h0};
    step(12'd3, 1'b1, 1'b0, 32'h7FC00000, "inf_minus_inf");
    weights_array = {32'h3F800000, 128'h0};
    step(12'd3, 1'b1, 1'b1, 32'h3F800000, "load_one");
    weights_array = {32'hBF800000, 128'h0};
    step(12'd3, 1'b1, 1'b0, 32'h00000000, "x_minus_x");
    weights_array = {32'h7F800001, 128'h0};
    step(12'd3, 1'b1, 1'b0, 32'h7FC00000, "nan_weight");
    step(12'd0, 1'b0, 1'b1, 32'h0,        "clear_nan");
    weights_array = {32'h00400000, 128'h0};
    step(12'd3, 1'b1, 1'b0, 32'h00000000, "subnormal_flush");
    weights_array = {32'h3F800000, 128'h0};
    step(12'd3, 1'b1, 1'b0, 32'h3F800000, "zero_plus_one");
    weights_array = {32'h33800000, 128'h0};
    step(12'd3, 1'b1, 1'b0, 32'h3F800000, "rne_tie_even");
    weights_array = {32'h33800001, 128'h0};
    step(12'd3, 1'b1, 1'b0, 32'h3F800001, "rne_round_up");

    repeat (3) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snn_mac.md
Name: snn_mac

Overview:
- Per-neuron synaptic accumulator for the spiking NoC neuron core.
- Holds a fan-in table of up to 5 source-neuron addresses, each with an IEEE-754 single-precision weight.
- On each incoming spike whose source address matches a table entry, adds that entry's weight to a running FP32 membrane-input sum.
- The sum is cleared at every timestep boundary and feeds the neuron's potential-update logic.

Parameters:
- NUM_SYN, 5: number of fan-in slots.
- ADDR_W, 12: neuron/source address width.
- DATA_W, 32: weight and accumulator width (FP32; fixed, not overridable).

Ports:
- CLK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous, active-low reset.
- neuron_address  in  ADDR_W  this neuron's own address.
- source_address  in  ADDR_W  address of the spiking source neuron this cycle.
- source_valid  in  1  high when source_address carries a spike this cycle.
- source_addresses_array  in  NUM_SYN*ADDR_W  fan-in address table; slot 0 is in the MSBs [59:48], slot 4 is in the LSBs [11:0].
- weights_array  in  NUM_SYN*DATA_W  FP32 weights; slot k pairs with address slot k; slot 0 is in [159:128].
- clear  in  1  synchronous timestep-boundary clear.
- mult_output  out  DATA_W  accumulated FP32 sum (registered).

Behaviour:
- Reset: when RESET_N is low, the accumulator and mult_output are 0x00000000 immediately, independent of CLK.
- Match (combinational):
  - hit = source_valid AND (source_address != neuron_address) AND source_address equals any slot address.
  - Self-spikes are always ignored.
  - If several slots match, the lowest slot index (MSB-most) wins; only one weight is added per cycle.
  - Padding slots use address 0 with weight 0.0, so a spike from address 0 adds +0.0.
- Each rising CLK edge, in priority order:
  - clear=1 and hit: acc <= selected weight (the spike opens the new timestep).
  - clear=1, no hit: acc <= 0x00000000.
  - clear=0 and hit: acc <= fp32_add(acc, weight).
  - otherwise: acc holds.
- mult_output = acc. Latency is 1 cycle from a spike being sampled to the updated sum appearing.
- FP add rules:
  - IEEE-754 binary32, round-to-nearest-even.
  - Subnormal inputs and results flush to +0.
  - Overflow gives ±Inf. Inf + (−Inf) gives canonical NaN 0x7FC00000; any NaN input gives 0x7FC00000.
  - x + (−x) gives +0.
- Table inputs (addresses, weights) are sampled live every cycle; the block stores no copy of them. Software must hold them stable within a timestep.
- A held source_valid with a constant address accumulates the weight once per cycle. The spike source must pulse valid for one cycle per spike.

Decomposition:
- Shared package snn_pkg: ADDR_W, NUM_SYN, FP32 constants (FP32_ZERO 32'h0, FP32_QNAN 32'h7FC00000, FP32_INF 32'h7F800000).
- One sub-module, fp32_adder: purely combinational, inputs a and b, output sum. Implements align, add/sub, normalise, RNE round, specials.
- Top level holds the match/select logic and the accumulator register.

Test Plan:
- Reset mid-accumulation: RESET_N low at any time -> mult_output 0x00000000 at once; stays 0 after release with no spikes.
- Full fan-in sum:
  - neuron_address 8, table {3,4,5,6,7}, weights {0x4290B333 (72.35), 0x41975C29 (18.92), 0x42470A3D (49.76), 0x0, 0x42AE3852 (87.11)}.
  - One-cycle spikes from 3, 4, 5, 7 -> mult_output 0x436423D7 (228.14), ±1 ulp vs. a software reference using the same operation order.
- Sparse table:
  - neuron_address 4, table {1,2,5,0,0}, weights {0x423F47AE (47.82), 0x4109999A (8.6), 0, 0, 0}.
  - Spikes 1 then 2 -> 0x4261AE14 (56.42). A spike from 9 -> unchanged.
- Clear interplay:
  - clear alone -> 0x0 next edge.
  - clear with a spike from 3 (neuron 8 setup) -> 0x4290B333.
- Self/duplicate cases:
  - source_address equal to neuron_address -> no change.
  - Table {3,3,0,0,0} with weights {1.0,2.0,...}, spike 3 -> +1.0 (0x3F800000) only.
- Specials:
  - acc 0x7F7FFFFF + weight 0x7F7FFFFF -> 0x7F800000.
  - Adding a NaN weight -> 0x7FC00000.
  - acc 1.0 + weight −1.0 -> 0x00000000.
